maxnet_loader: RTL and testbench

Upstream front-end and sequencer for the four-lane MaxNet datapath (`dataPath`). Accepts six 5-bit words serially over a valid/ready stream: x1..x4, then w1, then w2. It holds them stable on the datapath input buses and drives the datapath's `ld`/`sel` controls through one seed cycle and the iteration loop. When the datapath's `done` is seen, it returns the winning value on a valid/ready result port, with a timeout flag if `done` never arrives.

---
 rtl/maxnet_pkg.sv | 24 ++
 rtl/maxnet_loader_if.sv | 27 ++
 rtl/maxnet_iter_ctr.sv | 42 ++++
 rtl/maxnet_loader.sv | 132 +++++++++++++
 tb/tb_maxnet_loader.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/maxnet_pkg.sv
// Shared types and constants for the MaxNet loader/sequencer.
// Imported by the loader, its interface and the iteration counter.
package maxnet_pkg;

    localparam int W_DEF   = 5;
    localparam int N_SLOTS = 6;

    localparam int SLOT_X1 = 0;
    localparam int SLOT_X2 = 1;
    localparam int SLOT_X3 = 2;
    localparam int SLOT_X4 = 3;
    localparam int SLOT_W1 = 4;
    localparam int SLOT_W2 = 5;

    typedef enum logic [2:0] {
        ST_COLLECT,
        ST_LOAD,
        ST_SEED,
        ST_ITER,
        ST_CAPTURE,
        ST_OUT
    } state_e;

endpackage

// File: rtl/maxnet_loader_if.sv
// Operand input stream and result output stream of the loader.
// The master side feeds words and consumes results; the slave is the loader.
interface maxnet_loader_if
    import maxnet_pkg::*;
#(
    parameter int W = W_DEF
);

    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_max;
    logic         out_timeout;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_max, out_timeout, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_max, out_timeout, out_valid
    );

endinterface

// File: rtl/maxnet_iter_ctr.sv
// 8-bit iteration counter with clear/enable and a registered limit flag.
// hit rises the cycle after the count reaches ITER_MAX-1 while enabled.
module maxnet_iter_ctr
    import maxnet_pkg::*;
#(
    parameter int ITER_MAX = 31
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);

    logic [7:0] cnt_q, cnt_d;
    logic       hit_q, hit_d;

    always_comb begin
        cnt_d = cnt_q;
        hit_d = hit_q;
        if (clr) begin
            cnt_d = '0;
            hit_d = 1'b0;
        end else if (en) begin
            cnt_d = cnt_q + 8'd1;
            hit_d = (cnt_q == 8'(ITER_MAX - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
            hit_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            hit_q <= hit_d;
        end
    end

    assign hit = hit_q;

endmodule

// File: rtl/maxnet_loader.sv
// Serial operand loader and ld/sel sequencer for the four-lane MaxNet datapath.
// Collects x1..x4,w1,w2, runs seed + iteration loop, returns winner or timeout.
module maxnet_loader
    import maxnet_pkg::*;
#(
    parameter int W        = W_DEF,
    parameter int ITER_MAX = 31
) (
    input  logic         clk,
    input  logic         rst,
    maxnet_loader_if.slave bus,
    output logic [W-1:0] dp_x1,
    output logic [W-1:0] dp_x2,
    output logic [W-1:0] dp_x3,
    output logic [W-1:0] dp_x4,
    output logic [W-1:0] dp_w1,
    output logic [W-1:0] dp_w2,
    output logic         dp_ld,
    output logic         dp_sel,
    output logic         dp_clr,
    input  logic         dp_done,
    input  logic [W-1:0] dp_max,
    output logic         busy
);

    state_e       state_q, state_d;
    logic [2:0]   wcnt_q, wcnt_d;
    logic [W-1:0] opnd_q [N_SLOTS];
    logic [W-1:0] opnd_d [N_SLOTS];
    logic [W-1:0] out_max_q, out_max_d;
    logic         out_valid_q, out_valid_d;
    logic         out_to_q, out_to_d;
    logic         ctr_clr, ctr_en, ctr_hit;

    maxnet_iter_ctr #(
        .ITER_MAX (ITER_MAX)
    ) u_ctr (
        .clk (clk),
        .rst (rst),
        .clr (ctr_clr),
        .en  (ctr_en),
        .hit (ctr_hit)
    );

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        opnd_d      = opnd_q;
        out_max_d   = out_max_q;
        out_valid_d = out_valid_q;
        out_to_d    = out_to_q;
        ctr_clr     = 1'b0;
        ctr_en      = 1'b0;
        unique case (state_q)
            ST_COLLECT: begin
                if (bus.in_valid) begin
                    opnd_d[wcnt_q] = bus.in_data;
                    wcnt_d         = wcnt_q + 3'd1;
                    if (wcnt_q == 3'(SLOT_W2)) begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: state_d = ST_SEED;
            ST_SEED: state_d = ST_ITER;
            ST_ITER: begin
                ctr_en = 1'b1;
                if (dp_done) begin
                    state_d = ST_CAPTURE;
                end else if (ctr_hit) begin
                    state_d     = ST_OUT;
                    out_max_d   = '0;
                    out_to_d    = 1'b1;
                    out_valid_d = 1'b1;
                end
            end
            ST_CAPTURE: begin
                state_d     = ST_OUT;
                out_max_d   = dp_max;
                out_to_d    = 1'b0;
                out_valid_d = 1'b1;
            end
            ST_OUT: begin
                if (out_valid_q && bus.out_ready) begin
                    state_d     = ST_COLLECT;
                    wcnt_d      = '0;
                    out_valid_d = 1'b0;
                    out_to_d    = 1'b0;
                    ctr_clr     = 1'b1;
                end
            end
            default: state_d = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_COLLECT;
            wcnt_q      <= '0;
            opnd_q      <= '{default: '0};
            out_max_q   <= '0;
            out_valid_q <= 1'b0;
            out_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            opnd_q      <= opnd_d;
            out_max_q   <= out_max_d;
            out_valid_q <= out_valid_d;
            out_to_q    <= out_to_d;
        end
    end

    assign dp_x1 = opnd_q[SLOT_X1];
    assign dp_x2 = opnd_q[SLOT_X2];
    assign dp_x3 = opnd_q[SLOT_X3];
    assign dp_x4 = opnd_q[SLOT_X4];
    assign dp_w1 = opnd_q[SLOT_W1];
    assign dp_w2 = opnd_q[SLOT_W2];

    // Controls decode from state only; clear also asserts while in reset.
    assign dp_ld  = (state_q == ST_LOAD);
    assign dp_sel = (state_q == ST_ITER) || (state_q == ST_CAPTURE);
    assign dp_clr = !rst || (state_q == ST_LOAD);
    assign busy   = (state_q != ST_COLLECT);

    assign bus.in_ready    = (state_q == ST_COLLECT);
    assign bus.out_max     = out_max_q;
    assign bus.out_timeout = out_to_q;
    assign bus.out_valid   = out_valid_q;

endmodule

// File: tb/tb_maxnet_loader.sv
// Bench for maxnet_loader: vector table, stall/reset sequences, random runs
// against a cycle-count model with a behavioural datapath done/max source.
module tb_maxnet_loader;

    localparam int IM = 4;

    logic       clk;
    logic       rst;
    logic [4:0] dp_x1, dp_x2, dp_x3, dp_x4, dp_w1, dp_w2;
    logic       dp_ld, dp_sel, dp_clr, dp_done, busy;
    logic [4:0] dp_max;

    maxnet_loader_if #(.W(5)) bus ();

    maxnet_loader #(
        .W        (5),
        .ITER_MAX (IM)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .dp_x1   (dp_x1),
        .dp_x2   (dp_x2),
        .dp_x3   (dp_x3),
        .dp_x4   (dp_x4),
        .dp_w1   (dp_w1),
        .dp_w2   (dp_w2),
        .dp_ld   (dp_ld),
        .dp_sel  (dp_sel),
        .dp_clr  (dp_clr),
        .dp_done (dp_done),
        .dp_max  (dp_max),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural datapath: done on the chosen ITER cycle, constant max.
    int         done_at_r = 0;
    int         sel_cnt   = 0;
    logic [4:0] dpmax_r   = '0;

    always @(posedge clk) begin
        if (dp_ld) sel_cnt <= 0;
        else if (dp_sel) sel_cnt <= sel_cnt + 1;
    end

    assign dp_done = dp_sel && (done_at_r != 0) && (sel_cnt + 1 == done_at_r);
    assign dp_max  = dpmax_r;

    logic [4:0] bank [6];
    logic [4:0] dpv  [6];
    assign dpv[0] = dp_x1;
    assign dpv[1] = dp_x2;
    assign dpv[2] = dp_x3;
    assign dpv[3] = dp_x4;
    assign dpv[4] = dp_w1;
    assign dpv[5] = dp_w2;

    typedef struct {
        logic [29:0] words;
        int          mask;
        int          done_at;
        int          hold;
        int          emax;
        int          eto;
        int          elat;
    } vec_t;

    vec_t vec [7];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic logic [4:0] wsel(input logic [29:0] p, input int i);
        return p[5*(5-i) +: 5];
    endfunction

    function automatic int bank_bad();
        int n = 0;
        for (int i = 0; i < 6; i++) if (dpv[i] !== bank[i]) n++;
        return n;
    endfunction

    function automatic logic [4:0] maxx(input logic [29:0] p);
        logic [4:0] m = '0;
        for (int i = 0; i < 4; i++) if (wsel(p, i) > m) m = wsel(p, i);
        return m;
    endfunction

    function automatic void model(input logic [29:0] p, input int done_at,
                                  output int emax, output int eto,
                                  output int elat);
        if (done_at >= 1 && done_at <= IM + 1) begin
            emax = int'(maxx(p));
            eto  = 0;
            elat = 4 + done_at;
        end else begin
            emax = 0;
            eto  = 1;
            elat = IM + 4;
        end
    endfunction

    task automatic feed(input logic [29:0] p, input int mask);
        int bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (mask[i]) begin
                repeat (2) begin
                    bus.in_valid = 1'b0;
                    @(posedge clk); #1;
                    bad += bank_bad();
                    if (bus.in_ready !== 1'b1) bad++;
                end
            end
            bus.in_data  = wsel(p, i);
            bus.in_valid = 1'b1;
            if (bus.in_ready !== 1'b1) bad++;
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            bank[i] = wsel(p, i);
            bad += bank_bad();
        end
        last_acc = cyc;
        chk("collect_slots", bad, 0);
    endtask

    task automatic finish(input int hold, input int emax, input int eto,
                          input int elat);
        int bad = 0;
        int nld = 0;
        int tld = -1;
        int w   = 0;
        logic [4:0] m;
        while (bus.out_valid !== 1'b1 && w < 200) begin
            if (dp_ld === 1'b1) begin
                nld++;
                tld = cyc;
            end
            if (bus.in_ready !== 1'b0 || busy !== 1'b1) bad++;
            bad += bank_bad();
            @(posedge clk); #1;
            w++;
        end
        chk("result_bound", 32'(w < 200), 1);
        chk("latency", cyc - last_acc + 1, elat);
        chk("ld_pulses", nld, 1);
        chk("ld_cycle", tld - last_acc, 0);
        chk("out_max", 32'(bus.out_max), emax);
        chk("out_timeout", 32'(bus.out_timeout), eto);
        m = bus.out_max;
        repeat (hold) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b1 || bus.out_max !== m) bad++;
            if (bus.in_ready !== 1'b0 || busy !== 1'b1) bad++;
            bad += bank_bad();
        end
        chk("busy_phase", bad, 0);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("post_accept", {bus.out_valid, bus.in_ready, busy}, 3'b010);
    endtask

    task automatic run(input vec_t v);
        done_at_r = v.done_at;
        dpmax_r   = maxx(v.words);
        feed(v.words, v.mask);
        finish(v.hold, v.emax, v.eto, v.elat);
    endtask

    task automatic reset_chk(input string nm);
        chk({nm, "_ctl"}, {bus.in_ready, busy, dp_ld, dp_sel, dp_clr},
            5'b10001);
        chk({nm, "_out"}, {bus.out_valid, bus.out_timeout, bus.out_max},
            7'd0);
        chk({nm, "_bank"}, bank_bad(), 0);
    endtask

    initial begin
        int   w;
        vec_t rv;

        vec[0] = '{{5'd3, 5'd7, 5'd5, 5'd1, 5'd1, 5'd30}, 0, 3, 0, 7, 0, 7};
        vec[1] = '{{5'd3, 5'd7, 5'd5, 5'd1, 5'd1, 5'd30}, 62, 1, 0, 7, 0, 5};
        vec[2] = '{{5'd9, 5'd2, 5'd4, 5'd6, 5'd1, 5'd1}, 0, 0, 0, 0, 1, 8};
        vec[3] = '{{5'd9, 5'd2, 5'd4, 5'd6, 5'd1, 5'd1}, 0, 4, 0, 9, 0, 8};
        vec[4] = '{{5'd2, 5'd11, 5'd4, 5'd12, 5'd3, 5'd3}, 0, 5, 0, 12, 0, 9};
        vec[5] = '{{5'd31, 5'd0, 5'd31, 5'd0, 5'd5, 5'd5}, 5, 2, 5, 31, 0, 6};
        vec[6] = '{{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0}, 0, 1, 1, 0, 0, 5};

        for (int i = 0; i < 6; i++) bank[i] = '0;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_chk("reset");
        rst = 1'b1;
        #1;
        chk("clr_release", 32'(dp_clr), 0);

        for (int i = 0; i < 7; i++) run(vec[i]);

        done_at_r = 0;
        dpmax_r   = 5'd17;
        feed({5'd17, 5'd3, 5'd9, 5'd2, 5'd4, 5'd4}, 0);
        w = 0;
        while (dp_sel !== 1'b1 && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        chk("reach_iter", 32'(dp_sel), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) bank[i] = '0;
        reset_chk("midreset");
        rst = 1'b1;
        run('{{5'd3, 5'd7, 5'd5, 5'd1, 5'd1, 5'd30}, 62, 2, 0, 7, 0, 6});

        for (int n = 0; n < 16; n++) begin
            rv.words   = 30'($urandom);
            rv.mask    = int'($urandom_range(0, 63));
            rv.done_at = int'($urandom_range(0, IM + 2));
            rv.hold    = int'($urandom_range(0, 3));
            model(rv.words, rv.done_at, rv.emax, rv.eto, rv.elat);
            run(rv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
